tmds_encoder: RTL

TMDS_ENCODER -- requirements
Module: tmds_encoder

---
 rtl/tmds_pkg.sv | 15 +
 rtl/tm_choice.sv | 32 +++
 rtl/tmds_encoder.sv | 75 +++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS channel encoder: control symbols and
// the running-disparity tally type.
package tmds_pkg;

    localparam int CNT_W = 5;

    typedef logic signed [CNT_W-1:0] cnt_t;

    // Control-period symbols, indexed by {C1,C0}
    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

endpackage

// File: rtl/tm_choice.sv
// Transition-minimisation stage: turns a pixel byte into the 9-bit q_m
// word, choosing XOR or XNOR chaining to minimise transitions.
module tm_choice (
    input  logic [7:0] data,
    output logic [8:0] q_m
);

    // Bit 8 flags the chaining mode: 1 = XOR, 0 = XNOR.
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic       prev;
        logic [8:0] q;
        ones = '0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + 4'(d[i]);
        end
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        prev = d[0];
        q = '0;
        q[0] = prev;
        for (int i = 1; i < 8; i++) begin
            prev = use_xnor ? ~(prev ^ d[i]) : (prev ^ d[i]);
            q[i] = prev;
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    assign q_m = minimise(data);

endmodule

// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS channel encoder: one registered 10-bit symbol per pixel
// clock, DC-balanced with a signed running-disparity tally.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic [1:0] control_in,
    input  logic       ve_in,
    output logic [9:0] tmds_out
);

    logic [8:0] q_m;
    logic [3:0] n1;
    logic [3:0] n0;
    cnt_t       diff;
    cnt_t       cnt;
    cnt_t       cnt_next;
    logic [9:0] sym_next;

    tm_choice u_tm_choice (
        .data (data_in),
        .q_m  (q_m)
    );

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    assign n1   = count_ones(q_m[7:0]);
    assign n0   = 4'd8 - n1;
    assign diff = $signed({1'b0, n1}) - $signed({1'b0, n0});

    // Next symbol and next tally; sign tests use the registered tally.
    always_comb begin
        sym_next = '0;
        cnt_next = cnt;
        if (!ve_in) begin
            case (control_in)
                2'b00:   sym_next = CTRL_00;
                2'b01:   sym_next = CTRL_01;
                2'b10:   sym_next = CTRL_10;
                default: sym_next = CTRL_11;
            endcase
            cnt_next = '0;
        end else if ((cnt == 5'sd0) || (n1 == n0)) begin
            sym_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
            sym_next = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_next = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            sym_next = {1'b0, q_m[8], q_m[7:0]};
            cnt_next = cnt + diff - (q_m[8] ? 5'sd0 : 5'sd2);
        end
    end

    // Symbol and tally registers; reset clears both.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tmds_out <= '0;
            cnt      <= '0;
        end else begin
            tmds_out <= sym_next;
            cnt      <= cnt_next;
        end
    end

endmodule
